diff_scan: RTL and testbench
============================

# diff_scan

Parametrised, sequential successor to the single-result lowest-differing-bit finder. It accepts two WIDTH-bit operands and computes their XOR mask. It then emits every differing bit position, one per output beat, through a valid/ready stream, either LSB-first or MSB-first. It sits beside the RISC ALU/datapath wherever the full set of mismatching bit positions is needed, not just the first one. It also reports an equality flag and the total difference count.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a power of two, ≥ 2
- IDX_W, 5, index width; must equal $clog2(WIDTH)
- CNT_W, 6, count width; must equal IDX_W+1 so that WIDTH itself is representable

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- in_valid  in  1  operands a, b, msb_first presented
- in_ready  out  1  block can accept operands; equals (state == IDLE) and is 0 while rst_n is low
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- msb_first  in  1  scan order for this transaction (0 = LSB-first, 1 = MSB-first)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_idx  out  IDX_W  bit position of the current differing bit
- out_last  out  1  final beat of the transaction
- eq  out  1  a == b for the current transaction
- diff_count  out  CNT_W  popcount(a ^ b) for the current transaction
- busy  out  1  transaction in progress (state == SCAN)

## Operation
- States: IDLE, SCAN.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register mask = a ^ b, mode = msb_first, and diff_count = popcount(a ^ b).
  - Register eq = (a == b), then go to SCAN.
- SCAN:
  - out_valid = 1.
  - If mask == 0: one beat with out_idx = 0, out_last = 1, eq = 1.
  - Otherwise:
    - out_idx = index of the lowest set bit of mask (mode 0) or the highest set bit (mode 1).
    - out_last = 1 exactly when mask has one bit set.
- Beat handshake: a beat completes on out_valid & out_ready.
  - On completion, clear the reported bit in mask.
  - If out_last was 1, go to IDLE and drop out_valid.
- Stall: while out_valid & !out_ready, out_idx, out_last, eq, diff_count and mask hold stable.
- Operand hold: in_valid is ignored during SCAN. Operand changes while in_ready = 0 have no effect.
- Output hold in IDLE: eq and diff_count hold the last transaction's values until the next accept. out_valid = 0.
- out_idx, out_last, eq and diff_count are driven from registers or from registered mask only. The priority encode of the registered mask is permitted as combinational logic. There is no combinational path from a or b to the outputs.
- Arithmetic:
  - diff_count saturates at neither end; it ranges 0..WIDTH in CNT_W bits.
  - out_idx ranges 0..WIDTH-1.

## Timing
- Reset (rst_n low at a rising edge) produces:
  - state = IDLE, mask = 0, mode = 0.
  - out_valid = 0, out_idx = 0, out_last = 0.
  - eq = 0, diff_count = 0, busy = 0.
  - in_ready = 1 from the first edge with rst_n high.
- Reset mid-SCAN aborts the transaction. No further beats are emitted, and any partially drained mask is discarded.
- Latency: accept at edge k, first out_valid at edge k+1.
- Throughput:
  - With out_ready held at 1, one beat per cycle, so N differing bits take N cycles in SCAN.
  - A fully-equal transaction takes 1 SCAN cycle.
  - The next accept is possible no earlier than the cycle after the last beat completes, giving one IDLE cycle minimum between transactions.
- A last-beat handshake and in_valid in the same cycle: the operands are not accepted, because in_ready = 0 in that cycle.

## Test plan
- LSB-first, a=0x00000005, b=0x00000000, out_ready=1:
  - beats idx 0 then 2; out_last only on 2.
  - diff_count=2, eq=0, first out_valid one cycle after accept.
- Same operands with msb_first=1: beats idx 2 then 0; out_last on 0.
- a=b=0xDEADBEEF: single beat idx 0, out_last=1, eq=1, diff_count=0; back in IDLE the next cycle.
- a=0xFFFFFFFF, b=0, out_ready toggled pseudo-randomly:
  - 32 beats idx 0..31 in order.
  - idx and out_last are stable during every stall.
  - diff_count=32, out_last on 31.
- Reset after 3 beats of the previous scenario:
  - out_valid=0 and busy=0 after the reset edge; in_ready=1 once rst_n is high.
  - A new a=0x80000000, b=0 yields a single beat idx 31, out_last=1.
- in_valid held with changing a/b during SCAN of a=0x00000012, b=0:
  - in_ready=0 throughout.
  - Beats remain idx 1, 4.
  - With a WIDTH=8, IDX_W=3, CNT_W=4 instance, a=0xA5, b=0x5A gives idx 0..7 and diff_count=8.

Source files
------------

// File: rtl/diff_scan.sv
// Streams every differing bit position of two operands, one index per beat, LSB- or MSB-first.
// Latency: operands accepted at edge k, first beat valid after edge k; one beat per cycle when out_ready holds.
// Backpressure: out_ready low stalls the scan with idx/last/eq/count held; in_ready is low for the whole scan.
module diff_scan #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             eq,
   output logic [CNT_W-1:0] diff_count,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Scan-side registers: remaining differing bits, scan order, and the per-transaction summary.
   logic [WIDTH-1:0] mask_q;
   logic             mode_q;
   logic             eq_q;
   logic [CNT_W-1:0] cnt_q;

   // Operand-side combinational values; these only ever feed registers.
   logic [WIDTH-1:0] diff_w;
   logic [CNT_W-1:0] pop_w;

   // Encoder results on the registered mask.
   logic [IDX_W-1:0] lo_idx;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] sel_idx;
   logic             one_hot;
   logic             mask_zero;

   logic             accept;
   logic             beat_done;
   logic             last_beat;

   assign accept    = in_valid & in_ready;
   assign beat_done = out_valid & out_ready;

   // State register; synchronous reset returns to IDLE and abandons any scan in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept moves to SCAN, completion of the last beat returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (beat_done && last_beat) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // XOR mask of the incoming operands and its population count.
   always_comb begin
      diff_w = a ^ b;
      pop_w  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_w = pop_w + CNT_W'(diff_w[i]);
      end
   end

   // Lowest and highest set bit of the remaining mask; both read 0 when the mask is empty.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            lo_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (mask_q[i]) begin
            hi_idx = IDX_W'(i);
         end
      end
   end

   // Last beat is either the single bit left, or the lone beat of an equal transaction.
   always_comb begin
      mask_zero = (mask_q == '0);
      one_hot   = !mask_zero && ((mask_q & (mask_q - WIDTH'(1))) == '0);
      sel_idx   = mode_q ? hi_idx : lo_idx;
      last_beat = mask_zero || one_hot;
   end

   // Mask/summary registers: load on accept, clear the reported bit on each completed beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_q <= '0;
         mode_q <= 1'b0;
         eq_q   <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         mask_q <= diff_w;
         mode_q <= msb_first;
         eq_q   <= (a == b);
         cnt_q  <= pop_w;
      end else if (beat_done) begin
         mask_q <= mask_q & ~(WIDTH'(1) << sel_idx);
      end
   end

   // Outputs come from state and registered mask only; idx/last are forced to 0 outside SCAN.
   always_comb begin
      in_ready   = rst_n && (state_q == IDLE);
      busy       = (state_q == SCAN);
      out_valid  = (state_q == SCAN);
      out_idx    = '0;
      out_last   = 1'b0;
      eq         = eq_q;
      diff_count = cnt_q;
      if (state_q == SCAN) begin
         out_idx  = sel_idx;
         out_last = last_beat;
      end
   end

endmodule

// File: tb/tb_diff_scan.sv
// Directed bench for diff_scan: 32-bit instance for ordering/stall/reset cases, 8-bit instance for a full-width pattern.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready is toggled pseudo-randomly in one scenario; elsewhere held high.
module tb_diff_scan;

   logic        clk;
   logic        rst_n;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        msb_first;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic        out_last;
   logic        eq;
   logic [5:0]  diff_count;
   logic        busy;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        msb_first8;
   logic        out_valid8;
   logic        out_ready8;
   logic [2:0]  out_idx8;
   logic        out_last8;
   logic        eq8;
   logic [3:0]  diff_count8;
   logic        busy8;

   int          total;
   int          passes;
   int          fails;

   diff_scan #(.WIDTH(32), .IDX_W(5), .CNT_W(6)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .msb_first  (msb_first),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .eq         (eq),
      .diff_count (diff_count),
      .busy       (busy)
   );

   diff_scan #(.WIDTH(8), .IDX_W(3), .CNT_W(4)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid8),
      .in_ready   (in_ready8),
      .a          (a8),
      .b          (b8),
      .msb_first  (msb_first8),
      .out_valid  (out_valid8),
      .out_ready  (out_ready8),
      .out_idx    (out_idx8),
      .out_last   (out_last8),
      .eq         (eq8),
      .diff_count (diff_count8),
      .busy       (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge on the 32-bit instance (caller ensures IDLE).
   task automatic accept32(input logic [31:0] ta, input logic [31:0] tb, input logic tm);
      a         = ta;
      b         = tb;
      msb_first = tm;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   // Check the current beat, then let it complete (out_ready must be 1).
   task automatic beat32(input string tag, input int idx, input logic last);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_idx"},   32'(out_idx),   32'(idx));
      chk({tag, "_last"},  32'(out_last),  32'(last));
      step();
   endtask

   initial begin
      int e;
      int cyc;
      logic r;

      total = 0; passes = 0; fails = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; msb_first = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; msb_first8 = 1'b0; out_ready8 = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_eq",        32'(eq),        32'd0);
      chk("rst_count",     32'(diff_count), 32'd0);
      chk("rst_idx",       32'(out_idx),   32'd0);
      chk("rst_last",      32'(out_last),  32'd0);
      chk("rst_in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready_high", 32'(in_ready), 32'd1);

      // LSB-first, a=5: beats 0 then 2, first out_valid one edge after accept
      accept32(32'h5, 32'h0, 1'b0);
      chk("lsb_count",    32'(diff_count), 32'd2);
      chk("lsb_eq",       32'(eq),        32'd0);
      chk("lsb_in_ready", 32'(in_ready),  32'd0);
      chk("lsb_busy",     32'(busy),      32'd1);
      beat32("lsb_b0", 0, 1'b0);
      beat32("lsb_b1", 2, 1'b1);
      chk("lsb_idle_valid", 32'(out_valid), 32'd0);
      chk("lsb_idle_ready", 32'(in_ready),  32'd1);
      chk("lsb_idle_count", 32'(diff_count), 32'd2);
      step();

      // MSB-first, same operands: beats 2 then 0
      accept32(32'h5, 32'h0, 1'b1);
      beat32("msb_b0", 2, 1'b0);
      beat32("msb_b1", 0, 1'b1);
      chk("msb_idle_valid", 32'(out_valid), 32'd0);
      step();

      // Equal operands: single beat idx 0, last, eq=1, count 0
      accept32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      chk("eq_eq",    32'(eq),         32'd1);
      chk("eq_count", 32'(diff_count), 32'd0);
      beat32("eq_b0", 0, 1'b1);
      chk("eq_idle_valid", 32'(out_valid), 32'd0);
      chk("eq_idle_ready", 32'(in_ready),  32'd1);
      chk("eq_idle_eq",    32'(eq),        32'd1);
      step();

      // All bits differ, random backpressure: idx 0..31 in order, stable during stalls
      accept32(32'hFFFFFFFF, 32'h0, 1'b0);
      chk("all_count", 32'(diff_count), 32'd32);
      e = 0;
      cyc = 0;
      while (e < 32 && cyc < 400) begin
         chk("all_valid", 32'(out_valid), 32'd1);
         chk("all_idx",   32'(out_idx),   32'(e));
         chk("all_last",  32'(out_last),  32'(e == 31));
         chk("all_held_count", 32'(diff_count), 32'd32);
         r = 1'($urandom_range(0, 1));
         out_ready = r;
         step();
         if (r) e++;
         cyc++;
      end
      out_ready = 1'b1;
      chk("all_done_valid", 32'(out_valid), 32'd0);
      chk("all_done_ready", 32'(in_ready),  32'd1);
      step();

      // Reset after 3 beats aborts the scan
      accept32(32'hFFFFFFFF, 32'h0, 1'b0);
      beat32("abort_b0", 0, 1'b0);
      beat32("abort_b1", 1, 1'b0);
      beat32("abort_b2", 2, 1'b0);
      rst_n = 1'b0;
      step();
      chk("abort_valid",    32'(out_valid),  32'd0);
      chk("abort_busy",     32'(busy),       32'd0);
      chk("abort_count",    32'(diff_count), 32'd0);
      chk("abort_in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready_high", 32'(in_ready), 32'd1);
      step();
      accept32(32'h80000000, 32'h0, 1'b0);
      chk("top_count", 32'(diff_count), 32'd1);
      beat32("top_b0", 31, 1'b1);
      chk("top_idle_valid", 32'(out_valid), 32'd0);
      step();

      // in_valid held with changing operands during the scan of 0x12
      accept32(32'h12, 32'h0, 1'b0);
      in_valid = 1'b1;
      a = 32'hFFFF0000;
      b = 32'h1;
      chk("hold_ready0", 32'(in_ready), 32'd0);
      beat32("hold_b0", 1, 1'b0);
      a = 32'h0;
      b = 32'hFFFFFFFF;
      chk("hold_ready1", 32'(in_ready), 32'd0);
      beat32("hold_b1", 4, 1'b1);
      in_valid = 1'b0;
      chk("hold_idle_valid", 32'(out_valid),  32'd0);
      chk("hold_idle_count", 32'(diff_count), 32'd2);
      chk("hold_idle_eq",    32'(eq),         32'd0);
      step();

      // 8-bit instance: 0xA5 ^ 0x5A = 0xFF, idx 0..7, count 8
      a8 = 8'hA5;
      b8 = 8'h5A;
      msb_first8 = 1'b0;
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      chk("w8_count", 32'(diff_count8), 32'd8);
      chk("w8_eq",    32'(eq8),         32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("w8_valid", 32'(out_valid8), 32'd1);
         chk("w8_idx",   32'(out_idx8),   32'(i));
         chk("w8_last",  32'(out_last8),  32'(i == 7));
         step();
      end
      chk("w8_idle_valid", 32'(out_valid8), 32'd0);
      chk("w8_idle_ready", 32'(in_ready8),  32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
